// File: rtl/pc_sel_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sel_unit_if
//  Description : Next-PC source, branch, exception and vector-fetch signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sel_unit_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 6,
    parameter int SELW  = 3
) ();
    logic [NSRC*WIDTH-1:0] src_bus;
    logic [SELW-1:0]       pc_src;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  zero;
    logic                  br_inv;
    logic                  exc_req;
    logic [1:0]            exc_code;
    logic [7:0]            mem_byte;
    logic [WIDTH-1:0]      pc_out;
    logic [WIDTH-1:0]      epc_out;
    logic [WIDTH-1:0]      vec_addr;
    logic                  vec_rd;
    logic                  busy;
    logic                  sel_err;

    modport master (
        output src_bus, pc_src, pc_write, pc_write_cond, zero, br_inv,
               exc_req, exc_code, mem_byte,
        input  pc_out, epc_out, vec_addr, vec_rd, busy, sel_err
    );

    modport slave (
        input  src_bus, pc_src, pc_write, pc_write_cond, zero, br_inv,
               exc_req, exc_code, mem_byte,
        output pc_out, epc_out, vec_addr, vec_rd, busy, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sel_unit
//  Description : PC register with source mux, branch load and exception
//                vector-fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sel_unit #(
    parameter int               WIDTH    = 32,
    parameter int               NSRC     = 6,
    parameter int               SELW     = 3,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] VEC_BASE = 253
) (
    input  logic          clk,
    input  logic          reset,
    pc_sel_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXC_ADDR = 2'd1;
    localparam logic [1:0] S_EXC_WAIT = 2'd2;
    localparam logic [1:0] S_EXC_LOAD = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [1:0]       r_code;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_next_pc;
    logic             w_sel_ok;
    logic             w_taken;
    logic             w_fetch;

    always_comb begin
        w_next_pc = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.pc_src == SELW'(k)) begin
                w_next_pc = bus.src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_ok = (int'(bus.pc_src) < NSRC);
    assign w_taken  = bus.pc_write | (bus.pc_write_cond & (bus.zero ^ bus.br_inv));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_code    <= 2'd0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // An exception wins over any PC load requested in the same cycle
                    if (bus.exc_req) begin
                        r_epc   <= r_pc - WIDTH'(4);
                        r_code  <= (bus.exc_code == 2'd3) ? 2'd0 : bus.exc_code;
                        r_state <= S_EXC_ADDR;
                    end else if (w_taken) begin
                        if (w_sel_ok) begin
                            r_pc <= w_next_pc;
                        end else begin
                            r_sel_err <= 1'b1;
                        end
                    end
                end
                S_EXC_ADDR: r_state <= S_EXC_WAIT;
                S_EXC_WAIT: r_state <= S_EXC_LOAD;
                S_EXC_LOAD: begin
                    r_pc    <= WIDTH'(bus.mem_byte);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_fetch = (r_state == S_EXC_ADDR) || (r_state == S_EXC_WAIT);

    assign bus.pc_out   = r_pc;
    assign bus.epc_out  = r_epc;
    assign bus.vec_rd   = w_fetch;
    assign bus.vec_addr = w_fetch ? (VEC_BASE + WIDTH'(r_code)) : '0;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.sel_err  = r_sel_err;
endmodule
`default_nettype wire

// File: tb/tb_pc_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sel_unit
//  Description : Directed bench for pc_sel_unit with a cycle-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sel_unit;
    localparam int WIDTH = 32;
    localparam int NSRC  = 6;
    localparam int SELW  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [WIDTH-1:0] src [NSRC];

    pc_sel_unit_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    pc_sel_unit #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW),
        .RESET_PC(32'h0), .VEC_BASE(32'd253)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NSRC; k++) bus.src_bus[k*WIDTH +: WIDTH] = src[k];
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Model: exception progress is a count of cycles since the accept edge
    logic [WIDTH-1:0] m_pc, m_epc;
    int               m_code;
    int               m_since_exc = 0;
    bit               m_sel_err   = 0;
    bit               m_valid     = 0;

    always @(posedge clk) begin
        m_sel_err = 0;
        if (reset) begin
            m_pc = 32'h0; m_epc = 32'h0; m_since_exc = 0; m_valid = 1;
        end else if (m_since_exc == 0) begin
            if (bus.exc_req) begin
                m_epc       = m_pc - 32'd4;
                m_code      = (bus.exc_code == 2'd3) ? 0 : int'(bus.exc_code);
                m_since_exc = 1;
            end else if (bus.pc_write || (bus.pc_write_cond && (bus.zero != bus.br_inv))) begin
                if (int'(bus.pc_src) < NSRC) m_pc = src[bus.pc_src];
                else                         m_sel_err = 1;
            end
        end else if (m_since_exc == 3) begin
            m_pc        = {24'h0, bus.mem_byte};
            m_since_exc = 0;
        end else begin
            m_since_exc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc_out",   bus.pc_out,  m_pc);
            chk("epc_out",  bus.epc_out, m_epc);
            chk("busy",     32'(bus.busy),    32'(m_since_exc != 0));
            chk("vec_rd",   32'(bus.vec_rd),  32'(m_since_exc == 1 || m_since_exc == 2));
            chk("vec_addr", bus.vec_addr,
                (m_since_exc == 1 || m_since_exc == 2) ? 32'(253 + m_code) : 32'h0);
            chk("sel_err",  32'(bus.sel_err), 32'(m_sel_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NSRC; k++) src[k] = 32'((k + 2) * 16);
        bus.pc_src = '0; bus.pc_write = 0; bus.pc_write_cond = 0; bus.zero = 0;
        bus.br_inv = 0; bus.exc_req = 0; bus.exc_code = 0; bus.mem_byte = 0;
        cyc(); cyc();
        chk("rst_pc",   bus.pc_out,  32'h0);
        chk("rst_epc",  bus.epc_out, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset = 0;

        bus.pc_src = 3'd2; bus.pc_write = 1; cyc();
        chk("load_ch2", bus.pc_out, 32'h40);
        chk("load_selerr", 32'(bus.sel_err), 32'h0);

        // beq / bne, not-taken then taken
        bus.pc_write = 0; bus.pc_write_cond = 1; bus.br_inv = 0; bus.zero = 0; bus.pc_src = 3'd4;
        cyc(); chk("beq_nt", bus.pc_out, 32'h40);
        bus.zero = 1; cyc(); chk("beq_t", bus.pc_out, 32'h60);
        bus.br_inv = 1; bus.pc_src = 3'd0; cyc(); chk("bne_nt", bus.pc_out, 32'h60);
        bus.zero = 0; cyc(); chk("bne_t", bus.pc_out, 32'h20);
        bus.pc_write_cond = 0; bus.br_inv = 0;

        src[5] = 32'h100; bus.pc_src = 3'd5; bus.pc_write = 1; cyc();
        chk("load_100", bus.pc_out, 32'h100);

        // exception with a competing pc_write; later loads and requests ignored while busy
        bus.pc_src = 3'd0; bus.exc_req = 1; bus.exc_code = 2'd1; cyc();
        chk("exc_epc", bus.epc_out, 32'hFC);
        chk("exc_pc_held", bus.pc_out, 32'h100);
        chk("exc_vaddr1", bus.vec_addr, 32'd254);
        chk("exc_vrd1", 32'(bus.vec_rd), 32'h1);
        bus.mem_byte = 8'h7C; bus.pc_src = 3'd7; cyc();
        chk("exc_vaddr2", bus.vec_addr, 32'd254);
        chk("exc_vrd2", 32'(bus.vec_rd), 32'h1);
        chk("busy_selerr", 32'(bus.sel_err), 32'h0);
        cyc();
        chk("exc_vrd3", 32'(bus.vec_rd), 32'h0);
        chk("exc_busy3", 32'(bus.busy), 32'h1);
        bus.exc_req = 0; bus.pc_write = 0; cyc();
        chk("exc_pc_vec", bus.pc_out, 32'h7C);
        chk("exc_done", 32'(bus.busy), 32'h0);
        chk("exc_epc_kept", bus.epc_out, 32'hFC);

        // code 3 aliases to code 0; reset aborts in EXC_WAIT
        bus.exc_req = 1; bus.exc_code = 2'd3; cyc();
        chk("code3_vaddr", bus.vec_addr, 32'd253);
        chk("code3_epc", bus.epc_out, 32'h78);
        bus.exc_req = 0; cyc();
        reset = 1; bus.mem_byte = 8'h55; cyc();
        chk("abort_pc", bus.pc_out, 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_vrd", 32'(bus.vec_rd), 32'h0);
        reset = 0; cyc(); cyc();
        chk("abort_noload", bus.pc_out, 32'h0);

        // invalid selects
        bus.pc_src = 3'd7; bus.pc_write = 1; cyc();
        chk("inv7_pc", bus.pc_out, 32'h0);
        chk("inv7_err", 32'(bus.sel_err), 32'h1);
        bus.pc_write = 0; cyc();
        chk("inv7_err_clr", 32'(bus.sel_err), 32'h0);
        bus.pc_src = 3'd6; bus.pc_write_cond = 1; bus.zero = 1; cyc();
        chk("inv6_err", 32'(bus.sel_err), 32'h1);
        bus.pc_write_cond = 0; bus.zero = 0; cyc();

        // EPC wraps below zero; code 2 vector
        bus.exc_req = 1; bus.exc_code = 2'd2; cyc();
        chk("wrap_epc", bus.epc_out, 32'hFFFF_FFFC);
        chk("code2_vaddr", bus.vec_addr, 32'd255);
        bus.exc_req = 0; bus.mem_byte = 8'h80; cyc(); cyc(); cyc();
        chk("code2_pc", bus.pc_out, 32'h80);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
